// File: rtl/reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// reg_access_arbiter
//
// Purpose:
//   Shares one register file between two requesters (port 0 = I2C slave,
//   port 1 = local host). Each accepted access takes three cycles:
//   IDLE (request sampled) -> ACCESS (address/data/write strobe driven,
//   grant pulse) -> RESP (registered read data arrives), and the completion
//   pulse appears in the IDLE cycle that follows.
//
//   Address map: 0 .. C_NUM_OUTPUT_REGS-1 are writable output registers,
//   the next C_NUM_INPUT_REGS addresses are read-only input registers, and
//   everything above is unmapped. Writes outside the writable region and any
//   access to an unmapped address complete with an error. Writes to the
//   read-only region never reach the register file.
//
// Configuration:
//   REG_ARB_LOCK_EN - when defined, adds lock0/lock1 inputs. A granted access
//   with lock set makes that port the owner; the other port is not granted
//   until the owner completes an access with lock clear. When undefined the
//   arbiter is pure round-robin.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   reqN, weN             access request and write flag from port N
//   addrN, wdataN         register address and write data from port N
//   lockN                 bus lock request (REG_ARB_LOCK_EN only)
//   gntN                  one-cycle pulse: port N's request was accepted
//   ackN, rdataN, errN    completion pulse, read data, error flag for port N
//   reg_addr              register file address
//   reg_data_in           register file write data
//   reg_write_en          register file write strobe
//   reg_data_out          register file read data, valid one cycle after addr
// -----------------------------------------------------------------------------
module reg_access_arbiter #(
    parameter int C_NUM_OUTPUT_REGS = 4,
    parameter int C_NUM_INPUT_REGS  = 4
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0,
    input  logic       we0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
`ifdef REG_ARB_LOCK_EN
    input  logic       lock0,
`endif
    output logic       gnt0,
    output logic       ack0,
    output logic [7:0] rdata0,
    output logic       err0,

    input  logic       req1,
    input  logic       we1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
`ifdef REG_ARB_LOCK_EN
    input  logic       lock1,
`endif
    output logic       gnt1,
    output logic       ack1,
    output logic [7:0] rdata1,
    output logic       err1,

    output logic [7:0] reg_addr,
    output logic [7:0] reg_data_in,
    output logic       reg_write_en,
    input  logic [7:0] reg_data_out
);

    // Region limits widened by one bit so the sum cannot wrap for any
    // parameter pair that still fits an 8-bit address space.
    localparam logic [8:0] WR_LIMIT  = 9'(C_NUM_OUTPUT_REGS);
    localparam logic [8:0] MAP_LIMIT = 9'(C_NUM_OUTPUT_REGS + C_NUM_INPUT_REGS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t     state_reg;
    logic       last_reg;        // port granted most recently
    logic       port_reg;        // port owning the access in flight
    logic       we_reg;
    logic [7:0] addr_reg;
    logic [7:0] wdata_reg;
    logic       wen_reg;
    logic [1:0] gnt_reg;
    logic [1:0] ack_reg;
    logic [1:0] err_reg;
    logic [7:0] rdata_reg [2];
`ifdef REG_ARB_LOCK_EN
    logic       locked_reg;      // an owner currently holds the bus
    logic       owner_reg;       // which port holds it
`endif

    // -------------------------------------------------------------------------
    // Request side gathered into vectors so arbitration is index based
    // -------------------------------------------------------------------------
    logic [1:0] req_vec;
    logic [1:0] we_vec;
    logic [7:0] addr_vec  [2];
    logic [7:0] wdata_vec [2];

    assign req_vec      = {req1, req0};
    assign we_vec       = {we1, we0};
    assign addr_vec[0]  = addr0;
    assign addr_vec[1]  = addr1;
    assign wdata_vec[0] = wdata0;
    assign wdata_vec[1] = wdata1;
`ifdef REG_ARB_LOCK_EN
    logic [1:0] lock_vec;
    assign lock_vec = {lock1, lock0};
`endif

    function automatic logic in_write_region(input logic [7:0] a);
        return {1'b0, a} < WR_LIMIT;
    endfunction

    function automatic logic in_map(input logic [7:0] a);
        return {1'b0, a} < MAP_LIMIT;
    endfunction

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [1:0] elig;
    logic       any_req;
    logic       win;
    logic       sel_we;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;
    logic       access_err;

    always_comb begin
        elig = req_vec;
`ifdef REG_ARB_LOCK_EN
        // While locked only the owner may be granted; the other request
        // simply waits in IDLE.
        if (locked_reg) begin
            elig = req_vec & (owner_reg ? 2'b10 : 2'b01);
        end
`endif
        any_req = |elig;
        // Contention goes to the port that was not served last; a single
        // request goes to whoever is asking.
        if (elig == 2'b11) begin
            win = ~last_reg;
        end else begin
            win = elig[1];
        end
        sel_we    = we_vec[win];
        sel_addr  = addr_vec[win];
        sel_wdata = wdata_vec[win];

        access_err = (we_reg && !in_write_region(addr_reg)) || !in_map(addr_reg);
    end

    // -------------------------------------------------------------------------
    // Access sequencer with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;       // makes port 0 the first winner
            port_reg  <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wen_reg   <= 1'b0;
            gnt_reg   <= '0;
            ack_reg   <= '0;
            err_reg   <= '0;
            for (int i = 0; i < 2; i++) begin
                rdata_reg[i] <= '0;
            end
`ifdef REG_ARB_LOCK_EN
            locked_reg <= 1'b0;
            owner_reg  <= 1'b0;
`endif
        end else begin
            ack_reg <= '0;

            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        state_reg <= ACCESS;
                        port_reg  <= win;
                        last_reg  <= win;
                        we_reg    <= sel_we;
                        addr_reg  <= sel_addr;
                        wdata_reg <= sel_wdata;
                        gnt_reg   <= win ? 2'b10 : 2'b01;
                        // Writes into the read-only or unmapped range are
                        // blocked here so the file never sees them.
                        wen_reg   <= sel_we && in_write_region(sel_addr);
`ifdef REG_ARB_LOCK_EN
                        // Ownership follows the lock bit of every granted
                        // access, so an unlocked access by the owner frees
                        // the bus for the next IDLE.
                        locked_reg <= lock_vec[win];
                        owner_reg  <= win;
`endif
                    end
                end

                ACCESS: begin
                    gnt_reg   <= '0;
                    wen_reg   <= 1'b0;
                    state_reg <= RESP;
                end

                RESP: begin
                    state_reg          <= IDLE;
                    ack_reg[port_reg]  <= 1'b1;
                    err_reg[port_reg]  <= access_err;
                    // Unmapped reads return zero instead of whatever the
                    // file drives for an address it does not decode.
                    if (!we_reg) begin
                        rdata_reg[port_reg] <= in_map(addr_reg) ? reg_data_out : 8'h00;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                    wen_reg   <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign gnt0         = gnt_reg[0];
    assign gnt1         = gnt_reg[1];
    assign ack0         = ack_reg[0];
    assign ack1         = ack_reg[1];
    assign err0         = err_reg[0];
    assign err1         = err_reg[1];
    assign rdata0       = rdata_reg[0];
    assign rdata1       = rdata_reg[1];
    assign reg_addr     = addr_reg;
    assign reg_data_in  = wdata_reg;
    assign reg_write_en = wen_reg;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_access_arbiter
//
// Two requester drivers feed transactions from per-port queues. A monitor
// sampling 1 ns after each rising edge predicts the winner of every grant from
// the round-robin rule, keeps a reference copy of the writable registers, and
// pushes the expected completion (cycle, err, rdata) into a per-port queue;
// every ack pops and compares. A small register file model answers the DUT.
// -----------------------------------------------------------------------------
module tb_reg_access_arbiter;

    localparam int NOUT = 4;
    localparam int NIN  = 4;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       lock;
        logic [3:0] gap;
    } txn_t;

    typedef struct {
        int         cyc;
        logic       we;
        logic [7:0] addr;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req_d   [2];
    logic       we_d    [2];
    logic [7:0] addr_d  [2];
    logic [7:0] wdata_d [2];
`ifdef REG_ARB_LOCK_EN
    logic       lock_d  [2];
`endif
    logic       gnt0, gnt1, ack0, ack1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] reg_addr, reg_data_in, reg_data_out;
    logic       reg_write_en;
    logic [1:0] gnt_v;
    assign gnt_v = {gnt1, gnt0};

    reg_access_arbiter #(
        .C_NUM_OUTPUT_REGS(NOUT),
        .C_NUM_INPUT_REGS (NIN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req_d[0]),
        .we0         (we_d[0]),
        .addr0       (addr_d[0]),
        .wdata0      (wdata_d[0]),
`ifdef REG_ARB_LOCK_EN
        .lock0       (lock_d[0]),
`endif
        .gnt0        (gnt0),
        .ack0        (ack0),
        .rdata0      (rdata0),
        .err0        (err0),
        .req1        (req_d[1]),
        .we1         (we_d[1]),
        .addr1       (addr_d[1]),
        .wdata1      (wdata_d[1]),
`ifdef REG_ARB_LOCK_EN
        .lock1       (lock_d[1]),
`endif
        .gnt1        (gnt1),
        .ack1        (ack1),
        .rdata1      (rdata1),
        .err1        (err1),
        .reg_addr    (reg_addr),
        .reg_data_in (reg_data_in),
        .reg_write_en(reg_write_en),
        .reg_data_out(reg_data_out)
    );

    // ---------------- register file model (environment) ----------------
    logic [7:0] file_mem [NOUT];

    function automatic logic [7:0] in_val(input logic [7:0] a);
        return 8'hC0 ^ a;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NOUT; i++) file_mem[i] <= 8'h00;
        end else if (reg_write_en && reg_addr < 8'(NOUT)) begin
            file_mem[reg_addr[1:0]] <= reg_data_in;
        end
        if (reg_addr < 8'(NOUT))            reg_data_out <= file_mem[reg_addr[1:0]];
        else if (reg_addr < 8'(NOUT + NIN)) reg_data_out <= in_val(reg_addr);
        else                                reg_data_out <= 8'hEE;
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit mon_en   = 0;
    bit cont_phase = 0;
    int prev_gc  = -1;
    bit lock_phase = 0;
    int gnt_log [$];

    txn_t tx0_q [$];
    txn_t tx1_q [$];
    exp_t e0_q  [$];
    exp_t e1_q  [$];
    bit   busy  [2];
    int   gap_cnt [2];

    // reference model state
    logic [7:0] ref_mem [NOUT];
    logic [7:0] rd_m [2];
    logic       last_m;
`ifdef REG_ARB_LOCK_EN
    logic       locked_m;
    logic       owner_m;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic reset_model();
        last_m = 1'b1;
`ifdef REG_ARB_LOCK_EN
        locked_m = 1'b0;
        owner_m  = 1'b0;
`endif
        for (int i = 0; i < 2; i++) rd_m[i] = 8'h00;
        for (int i = 0; i < NOUT; i++) ref_mem[i] = 8'h00;
        e0_q.delete();
        e1_q.delete();
    endtask

    function automatic int tx_size(input int p);
        return (p == 0) ? tx0_q.size() : tx1_q.size();
    endfunction

    function automatic txn_t tx_front(input int p);
        return (p == 0) ? tx0_q[0] : tx1_q[0];
    endfunction

    task automatic tx_pop(input int p);
        if (p == 0) void'(tx0_q.pop_front());
        else        void'(tx1_q.pop_front());
    endtask

    task automatic push_tx(input int p, input logic we, input logic [7:0] a,
                           input logic [7:0] d, input logic lk, input logic [3:0] gap);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.lock = lk; t.gap = gap;
        if (p == 0) tx0_q.push_back(t);
        else        tx1_q.push_back(t);
    endtask

    // ---------------- drivers (both ports, on the falling edge) ----------------
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (busy[p] && gnt_v[p]) begin
                    tx_pop(p);
                    busy[p]  = 0;
                    req_d[p] = 1'b0;
                end
                if (!busy[p] && tx_size(p) != 0) begin
                    t = tx_front(p);
                    if (gap_cnt[p] < int'(t.gap)) begin
                        gap_cnt[p]++;
                    end else begin
                        gap_cnt[p] = 0;
                        busy[p]    = 1;
                        req_d[p]   = 1'b1;
                        we_d[p]    = t.we;
                        addr_d[p]  = t.addr;
                        wdata_d[p] = t.wdata;
`ifdef REG_ARB_LOCK_EN
                        lock_d[p]  = t.lock;
`endif
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic take_ack(input int p, input logic err_a, input logic [7:0] rd_a);
        exp_t e;
        if (((p == 0) ? e0_q.size() : e1_q.size()) == 0) begin
            n_checks++;
            $display("FAIL unexpected_ack: port%0d ack seen, expected none (cycle %0d)", p, cyc);
        end else begin
            if (p == 0) e = e0_q.pop_front();
            else        e = e1_q.pop_front();
            check($sformatf("ack_latency_p%0d", p), cyc, e.cyc);
            check($sformatf("err_p%0d", p), {31'b0, err_a}, {31'b0, e.err});
            check($sformatf("rdata_p%0d", p), {24'b0, rd_a}, {24'b0, e.rdata});
            $display("port%0d %s addr=0x%02h err=%0b rdata=0x%02h cycle=%0d",
                     p, e.we ? "WR" : "RD", e.addr, err_a, rd_a, cyc);
        end
    endtask

    initial begin
        logic [1:0] pend, elig;
        logic       w, wr_ok;
        logic [7:0] a;
        exp_t       e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mon_en) begin
                if (gnt_v != 2'b00) begin
                    pend = {req_d[1], req_d[0]};
                    elig = pend;
`ifdef REG_ARB_LOCK_EN
                    if (locked_m) elig = pend & (owner_m ? 2'b10 : 2'b01);
`endif
                    if (elig == 2'b00) begin
                        check("gnt_without_eligible_req", {30'b0, gnt_v}, 32'd0);
                    end else begin
                        w = (elig == 2'b11) ? ~last_m : elig[1];
                        check("gnt_winner", {30'b0, gnt_v}, w ? 32'd2 : 32'd1);
                        last_m = w;
                        if (lock_phase) gnt_log.push_back(int'(w));
`ifdef REG_ARB_LOCK_EN
                        locked_m = lock_d[w];
                        owner_m  = w;
`endif
                        a      = addr_d[w];
                        wr_ok  = we_d[w] && (int'(a) < NOUT);
                        e.cyc  = cyc + 2;
                        e.we   = we_d[w];
                        e.addr = a;
                        e.err  = (we_d[w] && int'(a) >= NOUT) || (int'(a) >= NOUT + NIN);
                        check("wen_access", {31'b0, reg_write_en}, {31'b0, wr_ok});
                        if (wr_ok) begin
                            check("wr_addr", {24'b0, reg_addr}, {24'b0, a});
                            check("wr_data", {24'b0, reg_data_in}, {24'b0, wdata_d[w]});
                            ref_mem[a[1:0]] = wdata_d[w];
                        end
                        if (!we_d[w]) begin
                            if (int'(a) < NOUT)            rd_m[w] = ref_mem[a[1:0]];
                            else if (int'(a) < NOUT + NIN) rd_m[w] = in_val(a);
                            else                           rd_m[w] = 8'h00;
                        end
                        e.rdata = rd_m[w];
                        if (w == 1'b0) e0_q.push_back(e);
                        else           e1_q.push_back(e);
                    end
                    if (cont_phase) begin
                        if (prev_gc >= 0) check("gnt_spacing", cyc - prev_gc, 32'd3);
                        prev_gc = cyc;
                    end
                end else begin
                    check("wen_outside_access", {31'b0, reg_write_en}, 32'd0);
                end
                if (ack0) take_ack(0, err0, rdata0);
                if (ack1) take_ack(1, err1, rdata1);
            end
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        while (tx0_q.size() != 0 || tx1_q.size() != 0 || busy[0] || busy[1] ||
               e0_q.size() != 0 || e1_q.size() != 0) begin
            @(posedge clk);
            n++;
            if (n > 3000) begin
                n_checks++;
                $display("FAIL drain_%s: traffic still pending after %0d cycles, expected idle", tag, n);
                break;
            end
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req_d[p] = 1'b0; we_d[p] = 1'b0; addr_d[p] = 8'h00; wdata_d[p] = 8'h00;
            busy[p] = 0; gap_cnt[p] = 0;
`ifdef REG_ARB_LOCK_EN
            lock_d[p] = 1'b0;
`endif
        end
        reset_model();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt",  {30'b0, gnt1, gnt0}, 32'd0);
        check("rst_ack",  {30'b0, ack1, ack0}, 32'd0);
        check("rst_err",  {30'b0, err1, err0}, 32'd0);
        check("rst_rdata0", {24'b0, rdata0}, 32'd0);
        check("rst_rdata1", {24'b0, rdata1}, 32'd0);
        check("rst_reg_addr", {24'b0, reg_addr}, 32'd0);
        check("rst_reg_data_in", {24'b0, reg_data_in}, 32'd0);
        check("rst_wen", {31'b0, reg_write_en}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;

        // both ports held continuously from reset: alternate, one grant per 3 cycles
        cont_phase = 1;
        prev_gc    = -1;
        for (int i = 0; i < 6; i++) begin
            push_tx(0, 1'b0, 8'($urandom_range(0, 9)), 8'h00, 1'b0, 4'd0);
            push_tx(1, 1'b0, 8'($urandom_range(0, 9)), 8'h00, 1'b0, 4'd0);
        end
        drain("continuous");
        cont_phase = 0;

        // directed accesses: write/read back, read-only write, unmapped read
        push_tx(0, 1'b1, 8'd2, 8'h5A, 1'b0, 4'd0);
        push_tx(0, 1'b0, 8'd2, 8'h00, 1'b0, 4'd0);
        push_tx(1, 1'b1, 8'd5, 8'h77, 1'b0, 4'd1);
        push_tx(1, 1'b0, 8'd8, 8'h00, 1'b0, 4'd0);
        push_tx(1, 1'b0, 8'd6, 8'h00, 1'b0, 4'd0);
        drain("directed");

`ifdef REG_ARB_LOCK_EN
        // port 0 locks, port 1 waits until port 0 completes an unlocked access
        lock_phase = 1;
        gnt_log.delete();
        push_tx(0, 1'b0, 8'd2, 8'h00, 1'b1, 4'd0);
        push_tx(0, 1'b0, 8'd4, 8'h00, 1'b0, 4'd4);
        push_tx(1, 1'b0, 8'd1, 8'h00, 1'b0, 4'd2);
        drain("lock");
        lock_phase = 0;
        check("lock_gnt_count", gnt_log.size(), 32'd3);
        if (gnt_log.size() == 3) begin
            check("lock_order0", gnt_log[0], 32'd0);
            check("lock_order1", gnt_log[1], 32'd0);
            check("lock_order2", gnt_log[2], 32'd1);
        end
`endif

        // randomized traffic from both ports
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < 2; p++) begin
                push_tx(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 10)),
                        8'($urandom), 1'b0, 4'($urandom_range(0, 4)));
            end
        end
        drain("random");

        // reset asserted in the middle of a write's ACCESS cycle
        mon_en = 0;
        @(negedge clk);
        req_d[0] = 1'b1; we_d[0] = 1'b1; addr_d[0] = 8'd1; wdata_d[0] = 8'h33;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!gnt0 && n < 10);
        check("abort_gnt_seen", {31'b0, gnt0}, 32'd1);
        check("abort_wen_high", {31'b0, reg_write_en}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_wen_dropped", {31'b0, reg_write_en}, 32'd0);
        check("abort_gnt_dropped", {31'b0, gnt0}, 32'd0);
        check("abort_reg_addr", {24'b0, reg_addr}, 32'd0);
        req_d[0] = 1'b0; we_d[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_ack", {30'b0, ack1, ack0}, 32'd0);
        end
        reset_model();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;
        repeat (4) @(posedge clk);
        // after release both ask at once; port 0 must win first
        push_tx(1, 1'b0, 8'd1, 8'h00, 1'b0, 4'd0);
        push_tx(0, 1'b0, 8'd1, 8'h00, 1'b0, 4'd0);
        drain("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 Parameter C_NUM_OUTPUT_REGS, default 4: count of writable output registers at addresses 0..C_NUM_OUTPUT_REGS-1.
REQ-002 Parameter C_NUM_INPUT_REGS, default 4: count of read-only input registers directly above the output registers.
REQ-003 Port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Ports reqN  in  1  (N=0,1)  access request from port N; port 0 is the I2C slave, port 1 is the local host.
REQ-006 Ports weN, addrN, wdataN  in  1, 8, 8  write flag, register address and write data for port N.
REQ-007 Ports gntN  out  1  one-cycle pulse; port N's request has been accepted.
REQ-008 Ports ackN, rdataN, errN  out  1, 8, 1  completion pulse, read data and error flag for port N.
REQ-009 Ports reg_addr, reg_data_in, reg_write_en  out  8, 8, 1  drive the register file's addr, dataIn and writeEn.
REQ-010 Port reg_data_out  in  8  register file dataOut, registered there, valid one cycle after reg_addr.

Function
REQ-011 FSM states: IDLE, ACCESS, RESP; IDLE -> ACCESS when any reqN is high; ACCESS -> RESP always; RESP -> IDLE always.
REQ-012 reqN sampled only in IDLE; requester holds req/we/addr/wdata stable until gntN, then drops req or presents its next access.
REQ-013 Arbitration round-robin: one request grants that port; two simultaneous requests grant the port not granted last; pointer initialised so port 0 wins first.
REQ-014 On the IDLE->ACCESS edge: latch winner's we/addr/wdata; gntN is high for exactly the ACCESS cycle.
REQ-015 ACCESS: reg_addr = latched addr, reg_data_in = latched wdata, reg_write_en = latched we AND addr < C_NUM_OUTPUT_REGS.
REQ-016 reg_write_en is high only in ACCESS; reg_addr and reg_data_in hold the last latched values in all other states.
REQ-017 RESP: on its ending edge, rdataN <= reg_data_out (reads only), ackN pulses for one cycle and errN is updated for the winner.
REQ-018 Latency: request sampled in cycle T -> gnt in T+1 -> ack and rdata in T+3; peak throughput one access per 3 cycles.
REQ-019 errN = 1 on a write to addr >= C_NUM_OUTPUT_REGS, or on any access with addr >= C_NUM_OUTPUT_REGS + C_NUM_INPUT_REGS; errN = 0 otherwise.
REQ-020 Writes return no data; rdataN holds its previous value.
REQ-021 Only the winner's ack/gnt/err/rdata change; the losing port's request stays pending and wins the next IDLE.

Reset
REQ-022 rst_n low asynchronously forces state IDLE, round-robin pointer to its reset value, and gntN, ackN, errN, reg_write_en to 0.
REQ-023 rst_n low also forces rdataN, reg_addr, reg_data_in and the latched fields to 0.
REQ-024 Reset asserted during ACCESS drops reg_write_en immediately; no ack is issued for the aborted access.

Configuration
REQ-025 Macro REG_ARB_LOCK_EN defined: add inputs lockN (1 bit, sampled with reqN).
REQ-026 With REG_ARB_LOCK_EN, a granted access with lock=1 makes that port owner; the other port is not granted until the owner completes an access with lock=0.
REQ-027 Macro REG_ARB_LOCK_EN undefined: no lockN ports; pure round-robin.

Verification
REQ-028 Port 0 writes addr 2 = 0x5A, then reads addr 2 -> reg_write_en pulses once with addr 2 and data 0x5A; read ack at T+3 with rdata0 = 0x5A, err0 = 0.
REQ-029 req0 and req1 high together from reset, held continuously -> grants alternate 0,1,0,1, one gnt every 3 cycles.
REQ-030 Port 1 writes addr 5 (input region) -> reg_write_en stays 0; ack1 pulses with err1 = 1.
REQ-031 Port 1 reads addr 8 with default parameters -> ack1 pulses with err1 = 1 and rdata1 = 0x00.
REQ-032 rst_n pulled low mid-ACCESS during a write -> reg_write_en drops immediately, state is IDLE, no ack; after release, port 0 is granted first.
REQ-033 With REG_ARB_LOCK_EN, port 0 reads with lock=1 while req1 is held -> port 0's next access is granted ahead of port 1; port 1 is granted after port 0 completes an access with lock0=0.
